// File: rtl/charge_ctrl_mc_pkg.sv
// Shared key codes, FSM state type and keypad decode for the charging controller.
// Latency: combinational helpers only.
// Backpressure: none; pure definitions.
package charge_ctrl_mc_pkg;

    localparam logic [3:0] KEY_WAKE = 4'd3;
    localparam logic [3:0] KEY_CLR  = 4'd7;
    localparam logic [3:0] KEY_OK   = 4'd11;
    localparam logic [3:0] KEY_NEXT = 4'd13;
    localparam logic [3:0] KEY_ZERO = 4'd12;

    typedef enum logic {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } state_t;

    // Scanner codes are laid out as a 4x4 grid; digit keys map to {valid, digit}.
    function automatic logic [4:0] key2digit(input logic [3:0] key);
        logic [4:0] r;
        r = 5'b0;
        case (key)
            4'd0:     r = {1'b1, 4'd1};
            4'd1:     r = {1'b1, 4'd2};
            4'd2:     r = {1'b1, 4'd3};
            4'd4:     r = {1'b1, 4'd4};
            4'd5:     r = {1'b1, 4'd5};
            4'd6:     r = {1'b1, 4'd6};
            4'd8:     r = {1'b1, 4'd7};
            4'd9:     r = {1'b1, 4'd8};
            4'd10:    r = {1'b1, 4'd9};
            KEY_ZERO: r = {1'b1, 4'd0};
            default:  r = 5'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/charge_ctrl_mc_if.sv
// Keypad-in / display-out bundle between scanner, controller and 7-segment drivers.
// Latency: wires only.
// Backpressure: none; EN is a level, every output is a status or a pulse.
interface charge_ctrl_mc_if #(
    parameter int NCH = 2,
    parameter int CW  = 1,
    parameter int MW  = 7,
    parameter int TW  = 6
);
    logic           EN;
    logic [3:0]     key_value;
    logic           start_1;
    logic [CW-1:0]  sel_ch;
    logic [MW-1:0]  outmoney;
    logic [TW-1:0]  outtime;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
    logic           reject;

    modport master (
        output EN, key_value,
        input  start_1, sel_ch, outmoney, outtime, busy, done, reject
    );

    modport slave (
        input  EN, key_value,
        output start_1, sel_ch, outmoney, outtime, busy, done, reject
    );
endinterface

// File: rtl/charge_ctrl_mc_channel.sv
// One charger: loads a time budget and counts it down one unit per TICK_DIV cycles.
// Latency: load visible next edge; done pulses on the edge time reaches 0.
// Backpressure: a load while busy is dropped; the caller rejects it beforehand.
module charge_ctrl_mc_channel #(
    parameter int TW       = 6,
    parameter int TICK_DIV = 250
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_time_i,
    output logic          busy_o,
    output logic [TW-1:0] time_o,
    output logic          done_o
);
    localparam int KW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic          busy_q, busy_d;
    logic [TW-1:0] time_q, time_d;
    logic [KW-1:0] tick_q, tick_d;
    logic          done_q, done_d;

    // Next state: load when free, otherwise run the prescaler and decrement at wrap.
    always_comb begin
        busy_d = busy_q;
        time_d = time_q;
        tick_d = tick_q;
        done_d = 1'b0;
        if (load_i && !busy_q) begin
            busy_d = 1'b1;
            time_d = load_time_i;
            tick_d = '0;
        end else if (busy_q) begin
            if (tick_q == KW'(TICK_DIV - 1)) begin
                tick_d = '0;
                time_d = time_q - 1'b1;
                if (time_q == TW'(1)) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    // State registers; reset aborts any charge without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            time_q <= '0;
            tick_q <= '0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            time_q <= time_d;
            tick_q <= tick_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign time_o = time_q;
    assign done_o = done_q;

endmodule

// File: rtl/charge_ctrl_mc.sv
// Multi-channel charging controller: keypad entry, channel select, confirm/reject, idle sleep.
// Latency: every keypress acts on its rising-EN cycle and shows on the next edge.
// Backpressure: confirm on a busy channel or with empty entry yields a reject pulse.
module charge_ctrl_mc
    import charge_ctrl_mc_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int DIGITS       = 2,
    parameter int MAX_MONEY    = 20,
    parameter int RATE         = 2,
    parameter int TICK_DIV     = 250,
    parameter int IDLE_TIMEOUT = 2500
) (
    input  logic             CLK,
    input  logic             RST,
    charge_ctrl_mc_if.slave  bus
);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MOD = 10 ** DIGITS;
    localparam int MW  = $clog2(MOD);
    localparam int TW  = $clog2(MAX_MONEY * RATE + 1);
    localparam int IW  = $clog2(IDLE_TIMEOUT + 1);

    state_t         state_q, state_d;
    logic           en_q;
    logic [MW-1:0]  entry_q, entry_d;
    logic [CW-1:0]  sel_q, sel_d;
    logic [IW-1:0]  idle_q, idle_d;
    logic           reject_q, reject_d;
    logic           load_en;

    logic           kp;
    logic [4:0]     dig;
    logic [31:0]    entry_cap;
    logic [TW-1:0]  entry_time;
    logic [NCH-1:0] busy_w;
    logic [NCH-1:0] done_w;
    logic [TW-1:0]  ch_time [NCH];
    logic           sel_busy;

    assign kp       = bus.EN & ~en_q;
    assign dig      = key2digit(bus.key_value);
    assign sel_busy = busy_w[sel_q];

    // Capped amount converted to time units; used both for loading and for the preview.
    always_comb begin
        entry_cap  = (32'(entry_q) > 32'(MAX_MONEY)) ? 32'(MAX_MONEY) : 32'(entry_q);
        entry_time = TW'(entry_cap * 32'(RATE));
    end

    // FSM next state, entry editing, channel select, confirm arbitration and idle counting.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        sel_d    = sel_q;
        idle_d   = '0;
        reject_d = 1'b0;
        load_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (kp && bus.key_value == KEY_WAKE) begin
                    state_d = ENTRY;
                    entry_d = '0;
                    sel_d   = '0;
                end
            end
            ENTRY: begin
                if (kp) begin
                    // Any keypress restarts the idle window, so it beats the timeout.
                    if (dig[4]) begin
                        entry_d = MW'((32'(entry_q) * 32'd10 + 32'(dig[3:0])) % 32'(MOD));
                    end else begin
                        case (bus.key_value)
                            KEY_CLR:  entry_d = '0;
                            KEY_NEXT: sel_d = (sel_q == CW'(NCH - 1)) ? '0 : sel_q + 1'b1;
                            KEY_OK: begin
                                // busy is the pre-edge value, so a channel finishing
                                // this very cycle still refuses the load.
                                if (entry_q != '0 && !sel_busy) begin
                                    load_en = 1'b1;
                                    entry_d = '0;
                                end else begin
                                    reject_d = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (entry_q == '0 && busy_w == '0) begin
                    if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers and keypad edge history.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            entry_q  <= '0;
            sel_q    <= '0;
            idle_q   <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= bus.EN;
            entry_q  <= entry_d;
            sel_q    <= sel_d;
            idle_q   <= idle_d;
            reject_q <= reject_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        charge_ctrl_mc_channel #(
            .TW       (TW),
            .TICK_DIV (TICK_DIV)
        ) u_ch (
            .clk         (CLK),
            .rst         (RST),
            .load_i      (load_en && (sel_q == CW'(g))),
            .load_time_i (entry_time),
            .busy_o      (busy_w[g]),
            .time_o      (ch_time[g]),
            .done_o      (done_w[g])
        );
    end

    assign bus.start_1  = (state_q == ENTRY);
    assign bus.sel_ch   = sel_q;
    assign bus.outmoney = entry_q;
    assign bus.outtime  = (state_q == IDLE) ? '0 : (sel_busy ? ch_time[sel_q] : entry_time);
    assign bus.busy     = busy_w;
    assign bus.done     = done_w;
    assign bus.reject   = reject_q;

endmodule

// File: tb/tb_charge_ctrl_mc.sv
// Bench for charge_ctrl_mc (NCH=2, defaults): keypad vector table plus timing corner sequences.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_charge_ctrl_mc;

    logic CLK;
    logic RST;
    int   cyc;
    int   n_cmp;
    int   n_fail;

    charge_ctrl_mc_if #(.NCH(2), .CW(1), .MW(7), .TW(6)) bus ();

    charge_ctrl_mc dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [3:0] key;
        logic       st;
        logic [6:0] m;
        logic [5:0] t;
        logic       s;
        logic       r;
        logic [1:0] b;
    } vec_t;

    vec_t tbl   [$];
    vec_t exp_q [$];

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic kp_on(input logic [3:0] k);
        bus.key_value = k;
        bus.EN = 1'b1;
        step();
    endtask

    task automatic kp_off();
        bus.EN = 1'b0;
        step();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.EN = 1'b0;
        bus.key_value = 4'd0;
        step();
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic add(input logic [3:0] k, input logic st, input int m, input int t,
                       input logic s, input logic r, input logic [1:0] b);
        vec_t v;
        v.key = k; v.st = st; v.m = 7'(m); v.t = 6'(t); v.s = s; v.r = r; v.b = b;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t e;
        int   t0;
        int   ndone;
        cyc = 0;
        n_cmp = 0;
        n_fail = 0;
        RST = 1'b1;
        bus.EN = 1'b0;
        bus.key_value = 4'd0;

        //      key  st m   t   s r b
        add(4'd0,  0, 0,  0,  0,0,2'b00); // digit ignored while asleep
        add(4'd3,  1, 0,  0,  0,0,2'b00); // wake
        add(4'd3,  1, 0,  0,  0,0,2'b00); // wake again is a no-op
        add(4'd0,  1, 1,  2,  0,0,2'b00);
        add(4'd4,  1, 14, 28, 0,0,2'b00);
        add(4'd11, 1, 0,  28, 0,0,2'b01); // load ch0, 14 -> 28
        add(4'd13, 1, 0,  0,  1,0,2'b01);
        add(4'd10, 1, 9,  18, 1,0,2'b01);
        add(4'd10, 1, 99, 40, 1,0,2'b01); // preview capped at 20
        add(4'd11, 1, 0,  40, 1,0,2'b11); // load ch1 with 20 -> 40
        add(4'd11, 1, 0,  40, 1,1,2'b11); // busy + empty -> reject
        add(4'd0,  1, 1,  40, 1,0,2'b11);
        add(4'd1,  1, 12, 40, 1,0,2'b11);
        add(4'd2,  1, 23, 40, 1,0,2'b11); // 123 wraps to 23
        add(4'd11, 1, 23, 40, 1,1,2'b11); // busy ch1 -> reject, entry kept
        add(4'd13, 1, 23, 28, 0,0,2'b11);
        add(4'd7,  1, 0,  28, 0,0,2'b11);
        add(4'd15, 1, 0,  28, 0,0,2'b11);
        add(4'd13, 1, 0,  40, 1,0,2'b11);
        add(4'd12, 1, 0,  40, 1,0,2'b11);
        add(4'd9,  1, 8,  40, 1,0,2'b11);

        // Reset state
        do_reset();
        chk("rst.start_1", 32'(bus.start_1), 0);
        chk("rst.outmoney", 32'(bus.outmoney), 0);
        chk("rst.outtime", 32'(bus.outtime), 0);
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.done", 32'(bus.done), 0);
        chk("rst.reject", 32'(bus.reject), 0);
        chk("rst.sel_ch", 32'(bus.sel_ch), 0);

        // Table-driven keypress vectors through the scoreboard queue
        for (int i = 0; i < tbl.size(); i++) begin
            exp_q.push_back(tbl[i]);
            kp_on(tbl[i].key);
            e = exp_q.pop_front();
            chk($sformatf("vec%0d.start_1", i), 32'(bus.start_1), 32'(e.st));
            chk($sformatf("vec%0d.outmoney", i), 32'(bus.outmoney), 32'(e.m));
            chk($sformatf("vec%0d.outtime", i), 32'(bus.outtime), 32'(e.t));
            chk($sformatf("vec%0d.sel_ch", i), 32'(bus.sel_ch), 32'(e.s));
            chk($sformatf("vec%0d.reject", i), 32'(bus.reject), 32'(e.r));
            chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(e.b));
            kp_off();
        end

        // Countdown of 14 -> 28 units at 250 cycles each
        do_reset();
        kp_on(4'd3); kp_off();
        kp_on(4'd0); kp_off();
        kp_on(4'd4); kp_off();
        kp_on(4'd11);
        t0 = cyc;
        chk("cd.busy_load", 32'(bus.busy), 1);
        chk("cd.outtime_load", 32'(bus.outtime), 28);
        kp_off();
        while (bus.done[0] !== 1'b1 && cyc - t0 < 8000) begin
            step();
            if (cyc - t0 == 250) chk("cd.outtime_250", 32'(bus.outtime), 27);
        end
        chk("cd.done_latency", 32'(cyc - t0), 7000);
        chk("cd.busy_after", 32'(bus.busy), 0);
        step();
        chk("cd.done_one_cycle", 32'(bus.done), 0);

        // EN held high counts as a single keypress
        do_reset();
        kp_on(4'd3); kp_off();
        bus.key_value = 4'd0;
        bus.EN = 1'b1;
        for (int i = 0; i < 5; i++) step();
        kp_off();
        chk("hold.outmoney", 32'(bus.outmoney), 1);

        // Idle timeout: falls asleep exactly 2500 edges after the last keypress
        do_reset();
        kp_on(4'd3);
        t0 = cyc;
        kp_off();
        while (bus.start_1 === 1'b1 && cyc - t0 < 3000) step();
        chk("to.sleep_latency", 32'(cyc - t0), 2500);
        do_reset();
        kp_on(4'd3);
        t0 = cyc;
        kp_off();
        while (cyc < t0 + 2499) step();
        chk("to.awake_2499", 32'(bus.start_1), 1);
        kp_on(4'd14);
        chk("to.kp_wins", 32'(bus.start_1), 1);
        t0 = cyc;
        kp_off();
        while (bus.start_1 === 1'b1 && cyc - t0 < 3000) step();
        chk("to.sleep_after_kp", 32'(cyc - t0), 2500);

        // Confirm on the exact edge ch0 finishes; ch1 keeps counting independently
        do_reset();
        kp_on(4'd3); kp_off();
        kp_on(4'd0); kp_off();
        kp_on(4'd11);
        t0 = cyc;
        kp_off();
        kp_on(4'd13); kp_off();
        kp_on(4'd5); kp_off();
        kp_on(4'd11); kp_off();
        chk("fin.busy_both", 32'(bus.busy), 3);
        kp_on(4'd13); kp_off();
        kp_on(4'd4); kp_off();
        while (cyc < t0 + 499) step();
        chk("fin.busy_before", 32'(bus.busy), 3);
        kp_on(4'd11);
        chk("fin.reject", 32'(bus.reject), 1);
        chk("fin.done", 32'(bus.done), 1);
        chk("fin.busy", 32'(bus.busy), 2);
        chk("fin.outmoney_kept", 32'(bus.outmoney), 4);
        kp_off();
        chk("fin.reject_pulse", 32'(bus.reject), 0);
        chk("fin.done_pulse", 32'(bus.done), 0);
        kp_on(4'd11);
        chk("fin.reload_busy", 32'(bus.busy), 3);
        chk("fin.reload_time", 32'(bus.outtime), 8);
        chk("fin.reload_reject", 32'(bus.reject), 0);
        kp_off();
        kp_on(4'd13);
        chk("fin.ch1_time", 32'(bus.outtime), 9);
        kp_off();

        // Asynchronous reset mid-countdown
        do_reset();
        kp_on(4'd3); kp_off();
        kp_on(4'd0); kp_off();
        kp_on(4'd11); kp_off();
        for (int i = 0; i < 100; i++) step();
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("arst.start_1", 32'(bus.start_1), 0);
        chk("arst.busy", 32'(bus.busy), 0);
        chk("arst.outtime", 32'(bus.outtime), 0);
        chk("arst.outmoney", 32'(bus.outmoney), 0);
        chk("arst.done", 32'(bus.done), 0);
        step();
        RST = 1'b0;
        ndone = 0;
        for (int i = 0; i < 700; i++) begin
            step();
            if (bus.done !== 2'b00) ndone++;
        end
        chk("arst.no_done", 32'(ndone), 0);
        chk("arst.busy_after", 32'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
